mul_sequencer: RTL and testbench



---
 rtl/mul_sequencer.sv | 95 +++++++++
 tb/tb_mul_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// Iterative shift-and-add multiplier that borrows the EX-stage ALU for its additions.
// Produces the low WORD_LEN bits of opA*opB (valid for signed and unsigned operands).
module mul_sequencer #(
  parameter int                     WORD_LEN    = 32,
  parameter int                     EXE_CMD_LEN = 4,
  parameter logic [EXE_CMD_LEN-1:0] EXE_ADD     = '0,
  parameter bit                     EARLY_EXIT  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WORD_LEN-1:0]    opA,
  input  logic [WORD_LEN-1:0]    opB,
  output logic                   busy,
  output logic                   done,
  output logic [WORD_LEN-1:0]    result,
  output logic [WORD_LEN-1:0]    aluVal1,
  output logic [WORD_LEN-1:0]    aluVal2,
  output logic [EXE_CMD_LEN-1:0] aluCmd,
  input  logic [WORD_LEN-1:0]    aluOut,
  output logic [1:0]             dbg_state_o
);

  // Handshake: start is a level request sampled only in IDLE or DONE; it is
  // accepted on that edge. busy is high for every RUN cycle, done pulses for
  // exactly one cycle afterwards, and result holds until the next acceptance.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [WORD_LEN-1:0] acc_q;
  logic [WORD_LEN-1:0] mcand_q;
  logic [WORD_LEN-1:0] mplier_q;
  logic [WORD_LEN-1:0] result_q;
  logic [5:0]          count_q;

  logic [WORD_LEN-1:0] acc_d;
  logic                last_d;

  always_comb begin
    acc_d  = mplier_q[0] ? aluOut : acc_q;
    // Early exit fires when no set bits remain after this iteration's shift.
    last_d = (count_q == 6'(WORD_LEN - 1)) ||
             (EARLY_EXIT && (mplier_q[WORD_LEN-1:1] == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            acc_q    <= '0;
            mcand_q  <= opA;
            mplier_q <= opB;
            count_q  <= '0;
            state_q  <= S_RUN;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 6'd1;
          if (last_d) begin
            result_q <= acc_d;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ALU operands depend only on state and registers, so they are stable all cycle.
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign result      = result_q;
  assign aluVal1     = (state_q == S_RUN) ? acc_q   : '0;
  assign aluVal2     = (state_q == S_RUN) ? mcand_q : '0;
  assign aluCmd      = EXE_ADD;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: two instances (early exit on / off), each wired to a
// behavioural adder ALU, checked against a product-and-latency reference model.
module tb_mul_sequencer;

  localparam logic [3:0] EXE_ADD = 4'b0000;

  logic        clk;
  logic        rst_s     [2];
  logic        start_s   [2];
  logic [31:0] opa_s     [2];
  logic [31:0] opb_s     [2];
  logic        busy_s    [2];
  logic        done_s    [2];
  logic [31:0] result_s  [2];
  logic [31:0] alu_v1    [2];
  logic [31:0] alu_v2    [2];
  logic [3:0]  alu_cmd   [2];
  logic [31:0] alu_out   [2];
  logic [1:0]  dbg_state [2];

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs and ALUs ----------------
  mul_sequencer #(.WORD_LEN(32), .EXE_CMD_LEN(4), .EXE_ADD(EXE_ADD), .EARLY_EXIT(1'b1)) u_dut_ee (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .opA(opa_s[0]), .opB(opb_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .result(result_s[0]),
    .aluVal1(alu_v1[0]), .aluVal2(alu_v2[0]), .aluCmd(alu_cmd[0]), .aluOut(alu_out[0]),
    .dbg_state_o(dbg_state[0])
  );

  mul_sequencer #(.WORD_LEN(32), .EXE_CMD_LEN(4), .EXE_ADD(EXE_ADD), .EARLY_EXIT(1'b0)) u_dut_full (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .opA(opa_s[1]), .opB(opb_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .result(result_s[1]),
    .aluVal1(alu_v1[1]), .aluVal2(alu_v2[1]), .aluCmd(alu_cmd[1]), .aluOut(alu_out[1]),
    .dbg_state_o(dbg_state[1])
  );

  assign alu_out[0] = (alu_cmd[0] == EXE_ADD) ? alu_v1[0] + alu_v2[0] : 32'h0;
  assign alu_out[1] = (alu_cmd[1] == EXE_ADD) ? alu_v1[1] + alu_v2[1] : 32'h0;

  // ---------------- reference model ----------------
  function automatic int exp_cycles(int idx, logic [31:0] b);
    if (idx == 1) return 32;
    for (int i = 31; i >= 0; i--) begin
      if (b[i]) return i + 1;
    end
    return 1;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b);
    start_s[idx] = 1'b1;
    opa_s[idx]   = a;
    opb_s[idx]   = b;
    exp_q.push_back(a * b);
    @(posedge clk);
    @(negedge clk);
    start_s[idx] = 1'b0;
  endtask

  // Counts busy cycles until done; optionally pulses a stray start after pulse_at busy cycles.
  task automatic wait_done(input int idx, input int n_exp, input int pulse_at, input string tag);
    int          busy_n = 0;
    int          gap_n  = 0;
    logic        seen   = 1'b0;
    logic [31:0] exp_r;
    for (int c = 0; c < 40; c++) begin
      if (done_s[idx]) begin
        seen = 1'b1;
        break;
      end
      if (busy_s[idx]) busy_n++;
      else gap_n++;
      start_s[idx] = (pulse_at > 0) && (busy_n == pulse_at);
      opa_s[idx]   = 32'hDEAD_BEEF;
      opb_s[idx]   = 32'h0000_0003;
      @(negedge clk);
    end
    start_s[idx] = 1'b0;
    exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, busy_n, n_exp);
    check({tag, "_idle_gap"}, gap_n, 0);
    if (seen) begin
      check({tag, "_busy_in_done"}, 32'(busy_s[idx]), 32'd0);
      check({tag, "_result"}, result_s[idx], exp_r);
      check({tag, "_alu_v1_idle"}, alu_v1[idx], 32'h0);
      check({tag, "_alu_v2_idle"}, alu_v2[idx], 32'h0);
      check({tag, "_alu_cmd"}, 32'(alu_cmd[idx]), 32'(EXE_ADD));
    end
  endtask

  task automatic mul(input int idx, input logic [31:0] a, input logic [31:0] b, input string tag);
    issue(idx, a, b);
    wait_done(idx, exp_cycles(idx, b), 0, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          idx;
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b1; start_s[i] = 1'b1; opa_s[i] = 32'd6; opb_s[i] = 32'd7;
    end

    // Reset held with start asserted.
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check("rst_busy", 32'(busy_s[i]), 32'd0);
        check("rst_done", 32'(done_s[i]), 32'd0);
        check("rst_result", result_s[i], 32'h0);
        check("rst_alu_v1", alu_v1[i], 32'h0);
        check("rst_alu_v2", alu_v2[i], 32'h0);
        check("rst_alu_cmd", 32'(alu_cmd[i]), 32'(EXE_ADD));
      end
    end
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b0; start_s[i] = 1'b0;
    end
    @(negedge clk);
    check("post_rst_busy", 32'(busy_s[0]), 32'd0);
    check("post_rst_busy_full", 32'(busy_s[1]), 32'd0);

    // Directed cases.
    mul(0, 32'd6, 32'd7, "basic_6x7");
    @(negedge clk);
    mul(0, 32'h1234_5678, 32'h0, "zero_b");
    @(negedge clk);
    mul(0, 32'h0, 32'h8000_0000, "zero_a_msb_b");
    @(negedge clk);
    mul(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "wrap");
    @(negedge clk);
    mul(0, 32'hFFFF_FFFD, 32'd5, "signed_neg3x5");

    // Back-to-back: new start issued during the DONE cycle.
    mul(0, 32'd3, 32'd4, "b2b");

    // Stray start mid-run must be ignored and must not disturb the held result.
    @(negedge clk);
    issue(0, 32'd5, 32'h0000_00F0);
    wait_done(0, 8, 2, "ignored_start");
    @(negedge clk);
    check("ignored_start_no_rerun", 32'(busy_s[0]), 32'd0);
    check("ignored_start_held", result_s[0], 32'h0000_04B0);

    // Reset in the second RUN cycle abandons the run.
    issue(0, 32'd9, 32'd9);
    @(negedge clk);
    rst_s[0] = 1'b1;
    @(negedge clk);
    rst_s[0] = 1'b0;
    void'(exp_q.pop_back());
    check("rst_mid_busy", 32'(busy_s[0]), 32'd0);
    check("rst_mid_result", result_s[0], 32'h0);
    begin
      int done_n = 0;
      repeat (6) begin
        @(negedge clk);
        if (done_s[0] || busy_s[0]) done_n++;
      end
      check("rst_mid_no_done", done_n, 0);
    end

    // Full-length instance.
    mul(1, 32'd9, 32'd9, "full_9x9");
    @(negedge clk);
    mul(1, 32'hFFFF_FFFD, 32'd5, "full_signed");

    // Randomized operands, alternating instances, sometimes back-to-back.
    for (int t = 0; t < 30; t++) begin
      idx = t % 2;
      a   = $urandom;
      b   = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      mul(idx, a, b, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
